// File: rtl/pkt_drain_scheduler_pkg.sv
// Shared definitions for the packet drain scheduler and the action engine.
// Holds the scheduler state encoding and the default drop-flag position
// inside an action word.
package pkt_drain_scheduler_pkg;

  // IDLE=0, HUNT=1, FWD=2, DROP=3; the action engine decodes these values.
  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StHunt = 2'd1,
    StFwd  = 2'd2,
    StDrop = 2'd3
  } sched_state_t;

  localparam int unsigned DEFAULT_DROP_BIT = 0;

endpackage

// File: rtl/pkt_drain_scheduler_action_queue.sv
// Synchronous FIFO holding action words in arrival order.
// Ports:
//   clk, rst      clock, asynchronous active-high reset
//   push, wdata   write one word (ignored while full)
//   pop, rdata    read one word (ignored while empty); rdata shows the head
//   full, empty   occupancy flags
module pkt_drain_scheduler_action_queue #(
  parameter int unsigned WIDTH = 64,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  // Pointers carry one extra wrap bit to tell full from empty.
  logic [AW:0] wr_ptr;
  logic [AW:0] rd_ptr;
  logic        do_push;
  logic        do_pop;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign rdata   = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Storage needs no reset: the pointers define which entries are valid.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/pkt_drain_scheduler.sv
// Packet drain scheduler: for each queued action, drains exactly one packet
// (SOP..EOP) from a first-word-fall-through packet FIFO, forwarding it to the
// dispatcher with the action attached, or discarding it when the action's
// drop bit is set. Non-SOP words found while looking for a packet start are
// discarded and flagged on sync_err.
// Ports:
//   clk, rst                       clock, asynchronous active-high reset
//   act_valid/act_ready/act_data   action input handshake
//   pf_empty/pf_data/pf_sop/pf_eop packet FIFO head, pf_rd_en pops it
//   out_valid/out_ready/out_data/out_sop/out_eop/out_action  dispatcher side
//   busy                           scheduler not idle
//   fwd_cnt, drop_cnt              wrapping packet counters
//   sync_err                       one pulse per discarded non-SOP word
module pkt_drain_scheduler
  import pkt_drain_scheduler_pkg::*;
#(
  parameter int unsigned ACTION_W  = 64,
  parameter int unsigned DATA_W    = 64,
  parameter int unsigned ACT_DEPTH = 4,
  parameter int unsigned DROP_BIT  = DEFAULT_DROP_BIT,
  parameter int unsigned CNT_W     = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                act_valid,
  output logic                act_ready,
  input  logic [ACTION_W-1:0] act_data,
  input  logic                pf_empty,
  input  logic [DATA_W-1:0]   pf_data,
  input  logic                pf_sop,
  input  logic                pf_eop,
  output logic                pf_rd_en,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [DATA_W-1:0]   out_data,
  output logic                out_sop,
  output logic                out_eop,
  output logic [ACTION_W-1:0] out_action,
  output logic                busy,
  output logic [CNT_W-1:0]    fwd_cnt,
  output logic [CNT_W-1:0]    drop_cnt,
  output logic                sync_err
);

  sched_state_t        state;
  logic                q_full;
  logic                q_empty;
  logic                q_push;
  logic                q_pop;
  logic [ACTION_W-1:0] q_head;

  assign act_ready = ~q_full;
  assign q_push    = act_valid & ~q_full;
  assign q_pop     = (state == StIdle) & ~q_empty;

  pkt_drain_scheduler_action_queue #(
    .WIDTH (ACTION_W),
    .DEPTH (ACT_DEPTH)
  ) u_action_queue (
    .clk   (clk),
    .rst   (rst),
    .push  (q_push),
    .wdata (act_data),
    .pop   (q_pop),
    .rdata (q_head),
    .full  (q_full),
    .empty (q_empty)
  );

  assign busy     = (state != StIdle);
  assign out_data = pf_data;

  always_comb begin
    out_valid = 1'b0;
    pf_rd_en  = 1'b0;
    sync_err  = 1'b0;
    out_sop   = 1'b0;
    out_eop   = 1'b0;
    unique case (state)
      StHunt: begin
        // The SOP word stays at the head; only stray words are popped here.
        pf_rd_en = ~pf_empty & ~pf_sop;
        sync_err = ~pf_empty & ~pf_sop;
      end
      StFwd: begin
        out_valid = ~pf_empty;
        pf_rd_en  = ~pf_empty & out_ready;
        out_sop   = pf_sop;
        out_eop   = pf_eop;
      end
      StDrop: begin
        pf_rd_en = ~pf_empty;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= StIdle;
      out_action <= '0;
      fwd_cnt    <= '0;
      drop_cnt   <= '0;
    end else begin
      unique case (state)
        StIdle: begin
          if (!q_empty) begin
            out_action <= q_head;
            state      <= StHunt;
          end
        end
        StHunt: begin
          if (!pf_empty && pf_sop) begin
            state <= out_action[DROP_BIT] ? StDrop : StFwd;
          end
        end
        StFwd: begin
          // An SOP seen here is just data; only EOP ends the packet.
          if (pf_rd_en && pf_eop) begin
            fwd_cnt <= fwd_cnt + CNT_W'(1);
            state   <= StIdle;
          end
        end
        StDrop: begin
          if (pf_rd_en && pf_eop) begin
            drop_cnt <= drop_cnt + CNT_W'(1);
            state    <= StIdle;
          end
        end
        default: state <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_pkt_drain_scheduler.sv
// Directed self-checking bench for pkt_drain_scheduler. A small FWFT packet
// FIFO model feeds the DUT; each scenario task checks outputs cycle by cycle.
module tb_pkt_drain_scheduler;

  localparam int unsigned ACTION_W = 64;
  localparam int unsigned DATA_W   = 64;
  localparam int unsigned CNT_W    = 16;

  logic                clk = 1'b0;
  logic                rst = 1'b1;
  logic                act_valid = 1'b0;
  logic                act_ready;
  logic [ACTION_W-1:0] act_data = '0;
  logic                pf_empty;
  logic [DATA_W-1:0]   pf_data;
  logic                pf_sop;
  logic                pf_eop;
  logic                pf_rd_en;
  logic                out_valid;
  logic                out_ready = 1'b0;
  logic [DATA_W-1:0]   out_data;
  logic                out_sop;
  logic                out_eop;
  logic [ACTION_W-1:0] out_action;
  logic                busy;
  logic [CNT_W-1:0]    fwd_cnt;
  logic [CNT_W-1:0]    drop_cnt;
  logic                sync_err;

  int checks   = 0;
  int failures = 0;

  // Packet FIFO model: entry = {sop, eop, data}.
  logic [DATA_W+1:0] pmem [64];
  logic [5:0]        ph = '0;
  logic [5:0]        pt = '0;

  assign pf_empty = (ph == pt);
  assign pf_sop   = pmem[ph][DATA_W+1];
  assign pf_eop   = pmem[ph][DATA_W];
  assign pf_data  = pmem[ph][DATA_W-1:0];

  always @(posedge clk) if (pf_rd_en && !pf_empty) ph <= ph + 6'd1;

  always #5 clk = ~clk;

  pkt_drain_scheduler dut (
    .clk        (clk),
    .rst        (rst),
    .act_valid  (act_valid),
    .act_ready  (act_ready),
    .act_data   (act_data),
    .pf_empty   (pf_empty),
    .pf_data    (pf_data),
    .pf_sop     (pf_sop),
    .pf_eop     (pf_eop),
    .pf_rd_en   (pf_rd_en),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_sop    (out_sop),
    .out_eop    (out_eop),
    .out_action (out_action),
    .busy       (busy),
    .fwd_cnt    (fwd_cnt),
    .drop_cnt   (drop_cnt),
    .sync_err   (sync_err)
  );

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic load(input logic sop, input logic eop, input logic [DATA_W-1:0] d);
    pmem[pt] = {sop, eop, d};
    pt = pt + 6'd1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    #1;
    checks++;
    if ({act_ready, busy, out_valid, pf_rd_en, sync_err} !== 5'b10000) begin
      failures++;
      $display("FAIL reset_flags got=%b exp=10000",
               {act_ready, busy, out_valid, pf_rd_en, sync_err});
    end
    checks++;
    if ({fwd_cnt, drop_cnt, out_action} !== '0) begin
      failures++;
      $display("FAIL reset_regs fwd=%h drop=%h act=%h exp=0", fwd_cnt, drop_cnt, out_action);
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_forward();
    load(1'b1, 1'b0, 64'hA0);
    load(1'b0, 1'b0, 64'hB0);
    load(1'b0, 1'b1, 64'hC0);
    out_ready = 1'b1;
    act_data  = 64'h10;
    act_valid = 1'b1;
    #1;
    checks++;
    if (act_ready !== 1'b1) begin
      failures++;
      $display("FAIL fwd_act_ready got=%b exp=1", act_ready);
    end
    tick();
    act_valid = 1'b0;
    #1;
    checks++;
    if (busy !== 1'b0) begin failures++; $display("FAIL fwd_idle busy got=%b exp=0", busy); end
    tick();
    #1;
    checks++;
    if ({busy, out_valid, pf_rd_en} !== 3'b100) begin
      failures++;
      $display("FAIL fwd_hunt got=%b exp=100", {busy, out_valid, pf_rd_en});
    end
    tick();
    #1;
    checks++;
    if ({out_valid, out_sop, out_eop, out_data, out_action} !== {3'b110, 64'hA0, 64'h10}) begin
      failures++;
      $display("FAIL fwd_word0 got=%b%b%b %h %h exp=110 a0 10",
               out_valid, out_sop, out_eop, out_data, out_action);
    end
    tick();
    #1;
    checks++;
    if ({out_valid, out_sop, out_eop, out_data} !== {3'b100, 64'hB0}) begin
      failures++;
      $display("FAIL fwd_word1 got=%b%b%b %h exp=100 b0", out_valid, out_sop, out_eop, out_data);
    end
    tick();
    #1;
    checks++;
    if ({out_valid, out_sop, out_eop, out_data, pf_rd_en} !== {3'b101, 64'hC0, 1'b1}) begin
      failures++;
      $display("FAIL fwd_word2 got=%b%b%b %h rd=%b exp=101 c0 rd=1",
               out_valid, out_sop, out_eop, out_data, pf_rd_en);
    end
    tick();
    #1;
    checks++;
    if ({busy, fwd_cnt} !== {1'b0, 16'd1}) begin
      failures++;
      $display("FAIL fwd_done busy=%b fwd=%0d exp busy=0 fwd=1", busy, fwd_cnt);
    end
  endtask

  task automatic test_drop();
    for (int i = 0; i < 4; i++) load(i == 0, i == 3, 64'hD0 + 64'(i));
    act_data  = 64'h11;
    act_valid = 1'b1;
    tick();
    act_valid = 1'b0;
    tick();
    #1;
    checks++;
    if ({busy, pf_rd_en} !== 2'b10) begin
      failures++;
      $display("FAIL drop_hunt got=%b exp=10", {busy, pf_rd_en});
    end
    for (int i = 0; i < 4; i++) begin
      tick();
      #1;
      checks++;
      if ({out_valid, pf_rd_en, pf_data} !== {2'b01, 64'hD0 + 64'(i)}) begin
        failures++;
        $display("FAIL drop_pop%0d got v=%b rd=%b d=%h exp v=0 rd=1 d=%h",
                 i, out_valid, pf_rd_en, pf_data, 64'hD0 + 64'(i));
      end
    end
    tick();
    #1;
    checks++;
    if ({busy, drop_cnt, fwd_cnt} !== {1'b0, 16'd1, 16'd1}) begin
      failures++;
      $display("FAIL drop_done busy=%b drop=%0d fwd=%0d exp 0 1 1", busy, drop_cnt, fwd_cnt);
    end
  endtask

  task automatic test_backpressure();
    logic [4:0]        rdy_seq;
    logic [DATA_W-1:0] exp_data [5];
    logic [4:0]        exp_sop;
    logic [4:0]        exp_eop;
    rdy_seq  = 5'b11001;  // bit i = out_ready in FWD cycle i
    exp_data = '{64'hE0, 64'hE1, 64'hE1, 64'hE1, 64'hE2};
    exp_sop  = 5'b00001;
    exp_eop  = 5'b10000;
    load(1'b1, 1'b0, 64'hE0);
    load(1'b0, 1'b0, 64'hE1);
    load(1'b0, 1'b1, 64'hE2);
    act_data  = 64'h20;
    act_valid = 1'b1;
    tick();
    act_valid = 1'b0;
    tick();
    for (int i = 0; i < 5; i++) begin
      tick();
      out_ready = rdy_seq[i];
      #1;
      checks++;
      if ({out_valid, pf_rd_en, out_sop, out_eop, out_data} !==
          {1'b1, rdy_seq[i], exp_sop[i], exp_eop[i], exp_data[i]}) begin
        failures++;
        $display("FAIL bp_cycle%0d got v=%b rd=%b s=%b e=%b d=%h exp v=1 rd=%b s=%b e=%b d=%h",
                 i, out_valid, pf_rd_en, out_sop, out_eop, out_data,
                 rdy_seq[i], exp_sop[i], exp_eop[i], exp_data[i]);
      end
    end
    tick();
    out_ready = 1'b1;
    #1;
    checks++;
    if ({busy, fwd_cnt} !== {1'b0, 16'd2}) begin
      failures++;
      $display("FAIL bp_done busy=%b fwd=%0d exp busy=0 fwd=2", busy, fwd_cnt);
    end
  endtask

  task automatic test_resync();
    load(1'b0, 1'b0, 64'hF0);
    load(1'b0, 1'b1, 64'hF1);
    load(1'b1, 1'b1, 64'hF2);
    act_data  = 64'h30;
    act_valid = 1'b1;
    tick();
    act_valid = 1'b0;
    for (int i = 0; i < 2; i++) begin
      tick();
      #1;
      checks++;
      if ({sync_err, pf_rd_en, out_valid} !== 3'b110) begin
        failures++;
        $display("FAIL resync_err%0d got=%b exp=110", i, {sync_err, pf_rd_en, out_valid});
      end
    end
    tick();
    #1;
    checks++;
    if ({sync_err, pf_rd_en, out_valid} !== 3'b000) begin
      failures++;
      $display("FAIL resync_sop_hold got=%b exp=000", {sync_err, pf_rd_en, out_valid});
    end
    tick();
    #1;
    checks++;
    if ({out_valid, out_sop, out_eop, out_data, out_action} !== {3'b111, 64'hF2, 64'h30}) begin
      failures++;
      $display("FAIL resync_word got=%b%b%b %h %h exp=111 f2 30",
               out_valid, out_sop, out_eop, out_data, out_action);
    end
    tick();
    #1;
    checks++;
    if ({busy, fwd_cnt} !== {1'b0, 16'd3}) begin
      failures++;
      $display("FAIL resync_done busy=%b fwd=%0d exp busy=0 fwd=3", busy, fwd_cnt);
    end
  endtask

  task automatic test_queue_full();
    logic [ACTION_W-1:0] acts [5];
    int got;
    acts = '{64'h40, 64'h42, 64'h44, 64'h46, 64'h48};
    for (int i = 0; i < 5; i++) begin
      act_data  = acts[i];
      act_valid = 1'b1;
      #1;
      checks++;
      if (act_ready !== 1'b1) begin
        failures++;
        $display("FAIL qfull_push%0d act_ready got=%b exp=1", i, act_ready);
      end
      tick();
    end
    act_data = 64'h4A;
    #1;
    checks++;
    if ({act_ready, out_action} !== {1'b0, 64'h40}) begin
      failures++;
      $display("FAIL qfull_sixth ready=%b act=%h exp ready=0 act=40", act_ready, out_action);
    end
    tick();
    act_valid = 1'b0;
    for (int i = 0; i < 5; i++) load(1'b1, 1'b1, 64'h100 + 64'(i));
    got = 0;
    for (int c = 0; c < 100 && got < 5; c++) begin
      tick();
      #1;
      if (out_valid && out_ready) begin
        checks++;
        if ({out_action, out_data} !== {acts[got], 64'h100 + 64'(got)}) begin
          failures++;
          $display("FAIL qfull_order%0d act=%h d=%h exp act=%h d=%h",
                   got, out_action, out_data, acts[got], 64'h100 + 64'(got));
        end
        got++;
      end
    end
    checks++;
    if (got != 5) begin
      failures++;
      $display("FAIL qfull_timeout packets got=%0d exp=5", got);
    end
    tick();
    #1;
    checks++;
    if ({busy, act_ready, fwd_cnt} !== {2'b01, 16'd8}) begin
      failures++;
      $display("FAIL qfull_done busy=%b ready=%b fwd=%0d exp 0 1 8", busy, act_ready, fwd_cnt);
    end
  endtask

  task automatic test_reset_mid_fwd();
    load(1'b1, 1'b0, 64'h200);
    load(1'b0, 1'b0, 64'h201);
    load(1'b0, 1'b1, 64'h202);
    act_data  = 64'h50;
    act_valid = 1'b1;
    tick();
    act_valid = 1'b0;
    tick();
    tick();
    #1;
    checks++;
    if ({out_valid, pf_rd_en, out_data} !== {2'b11, 64'h200}) begin
      failures++;
      $display("FAIL rstmid_word0 v=%b rd=%b d=%h exp 1 1 200", out_valid, pf_rd_en, out_data);
    end
    tick();
    rst = 1'b1;
    #1;
    checks++;
    if ({out_valid, pf_rd_en, busy, act_ready} !== 4'b0001) begin
      failures++;
      $display("FAIL rstmid_outs got=%b exp=0001", {out_valid, pf_rd_en, busy, act_ready});
    end
    checks++;
    if ({fwd_cnt, drop_cnt, out_action} !== '0) begin
      failures++;
      $display("FAIL rstmid_regs fwd=%h drop=%h act=%h exp=0", fwd_cnt, drop_cnt, out_action);
    end
    tick();
    rst = 1'b0;
    load(1'b1, 1'b1, 64'h300);
    act_data  = 64'h60;
    act_valid = 1'b1;
    tick();
    act_valid = 1'b0;
    for (int i = 0; i < 2; i++) begin
      tick();
      #1;
      checks++;
      if ({sync_err, pf_rd_en, pf_data} !== {2'b11, 64'h201 + 64'(i)}) begin
        failures++;
        $display("FAIL rstmid_flush%0d err=%b rd=%b d=%h exp 1 1 %h",
                 i, sync_err, pf_rd_en, pf_data, 64'h201 + 64'(i));
      end
    end
    tick();
    tick();
    #1;
    checks++;
    if ({out_valid, out_sop, out_eop, out_data, out_action} !== {3'b111, 64'h300, 64'h60}) begin
      failures++;
      $display("FAIL rstmid_next got=%b%b%b %h %h exp=111 300 60",
               out_valid, out_sop, out_eop, out_data, out_action);
    end
    tick();
    #1;
    checks++;
    if ({busy, fwd_cnt, drop_cnt} !== {1'b0, 16'd1, 16'd0}) begin
      failures++;
      $display("FAIL rstmid_done busy=%b fwd=%0d drop=%0d exp 0 1 0", busy, fwd_cnt, drop_cnt);
    end
  endtask

  initial begin
    for (int i = 0; i < 64; i++) pmem[i] = '0;
    test_reset();
    test_forward();
    test_drop();
    test_backpressure();
    test_resync();
    test_queue_full();
    test_reset_mid_fwd();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pkt_drain_scheduler.md
Name: pkt_drain_scheduler

Overview:
- Sequences the packet FIFO that feeds the dispatcher. Actions from the action engine are queued in arrival order.
- For each queued action, exactly one packet (SOP..EOP) is drained from the packet FIFO. The packet is forwarded with its action attached, or discarded when the action's drop bit is set.
- Sits between the action/parser front end and the dispatcher. It replaces per-action single-cycle drain pulses with a full packet-level handshake.

Parameters:
- ACTION_W, 64, action word width
- DATA_W, 64, packet data word width
- ACT_DEPTH, 4, action queue depth (power of 2, >=2)
- DROP_BIT, 0, index of the drop flag inside the action word
- CNT_W, 16, width of the statistics counters

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- act_valid  in  1  action word offered
- act_ready  out  1  action queue not full; transfer when act_valid&act_ready
- act_data  in  ACTION_W  action word
- pf_empty  in  1  packet FIFO empty (FWFT: pf_data/pf_sop/pf_eop valid when !pf_empty)
- pf_data  in  DATA_W  packet FIFO head word
- pf_sop  in  1  head word is start of packet
- pf_eop  in  1  head word is end of packet
- pf_rd_en  out  1  pop packet FIFO head this cycle
- out_valid  out  1  word presented to dispatcher
- out_ready  in  1  dispatcher accepts; transfer when out_valid&out_ready
- out_data  out  DATA_W  = pf_data
- out_sop  out  1  = pf_sop during forward
- out_eop  out  1  = pf_eop during forward
- out_action  out  ACTION_W  action bound to current packet, stable for whole packet
- busy  out  1  state != IDLE
- fwd_cnt  out  CNT_W  packets forwarded (counted on EOP transfer)
- drop_cnt  out  CNT_W  packets dropped (counted on EOP pop)
- sync_err  out  1  one-cycle pulse per non-SOP word discarded while hunting

Behaviour:
- Reset (async, rst=1): state IDLE; action queue empty; out_action=0; fwd_cnt=drop_cnt=0; sync_err=0.
  - act_ready=1 after reset.
  - All combinational outputs (pf_rd_en, out_valid) are 0 while in IDLE.
- Action queue: FIFO of ACT_DEPTH entries.
  - act_ready = !full.
  - A push while full cannot occur by handshake.
  - A simultaneous push and pop when full is not allowed (act_ready=0); when empty, the push is stored and the pop does not occur.
- States:
  - IDLE: when the queue is non-empty, pop the head into out_action (registered) and go to HUNT. Latency is 1 cycle from action acceptance into an empty queue to entering HUNT.
  - HUNT: waits for an SOP at the packet FIFO head.
    - If !pf_empty & !pf_sop: pf_rd_en=1, sync_err=1 that cycle, stay in HUNT.
    - If !pf_empty & pf_sop: go to FWD when out_action[DROP_BIT]=0, else DROP. The SOP word is not popped in HUNT.
  - FWD: out_valid = !pf_empty; pf_rd_en = out_valid & out_ready.
    - On a transfer with pf_eop=1: fwd_cnt++, go to IDLE.
    - An SOP+EOP single-word packet is legal.
    - The dispatcher may stall indefinitely. out_valid only drops when the FIFO empties.
  - DROP: out_valid=0; pf_rd_en = !pf_empty.
    - On a pop with pf_eop=1: drop_cnt++, go to IDLE.
- An SOP seen mid-packet in FWD/DROP (EOP missing) is treated as a data word. No recovery is attempted.
- Back-to-back: the EOP cycle returns to IDLE and the next action is popped the following cycle, so there is a 2-cycle minimum gap between an EOP pop and the next SOP pop.
- Counters wrap modulo 2^CNT_W without saturation.
- out_action changes only on an IDLE pop.
- Reset asserted mid-packet aborts immediately. The remaining packet words are discarded by HUNT after reset.

Decomposition:
- Shared package: state encoding (IDLE=0, HUNT=1, FWD=2, DROP=3) and the DROP_BIT default, shared with the action engine.
- Sub-module: action_queue (parameterised sync FIFO, ACTION_W x ACT_DEPTH, full/empty, async active-high reset), instantiated once.

Test Plan:
- Forward: push action 0x10 (drop=0); FIFO holds a 3-word packet A,B,C(EOP); out_ready=1 → out_valid for 3 consecutive cycles, out_action=0x10, out_sop on A, out_eop on C, fwd_cnt=1, then IDLE.
- Drop: push action 0x11 (bit0=1); 4-word packet → 4 pops with out_valid=0, drop_cnt=1, fwd_cnt unchanged.
- Backpressure: out_ready toggles 1,0,0,1,1 on a 3-word packet → pops only on ready cycles, data/sop/eop stable during stalls, completes on the 5th cycle.
- Resync: FIFO head holds 2 non-SOP words then a 1-word SOP+EOP packet; one action pushed → sync_err pulses twice, then one word forwarded with sop=eop=1.
- Queue full: push 5 actions with ACT_DEPTH=4 and the FIFO empty → after the 1st action is popped to out_action, 4 are queued; act_ready=0 on the 6th attempt. Draining 5 packets yields out_action values in push order.
- Async reset mid-FWD: assert rst after word 1 of 3 → outputs 0 within the same cycle, counters 0. After release and a new action, the 2 leftover words are flushed with 2 sync_err pulses before the next SOP.
